skid_fifo: RTL and testbench
============================

Name: skid_fifo

Overview:
- Parametrised successor to the single-entry skid buffer: a DEPTH-entry elastic buffer between two valid/ready interfaces.
- Both handshake outputs (in_ready, out_valid) come straight from flops, so no combinational path exists between the two sides.
- Sustains one beat per cycle, for use in AXI, AXI-Lite and AXI-Stream cores where timing closure needs more than one slot of slack.
- Adds an asynchronous active-low reset and an occupancy output; the single-entry buffer has neither.

Parameters:
- DATA_WIDTH, 32, payload width in bits.
- DEPTH, 4, number of storage entries. Must be a power of two and at least 2; any other value is an elaboration error.

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  asynchronous active-low reset.
- in_data  input  DATA_WIDTH  upstream payload.
- in_valid  input  1  upstream valid.
- in_ready  output  1  registered ready to upstream.
- out_data  output  DATA_WIDTH  downstream payload, driven from storage.
- out_valid  output  1  registered valid to downstream.
- out_ready  input  1  downstream ready.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Clock and reset (already decided): one clock, clk. resetn is asynchronous and active-low.
- Reset asserted: immediately, with no clock edge, wr_ptr=0, rd_ptr=0, count=0, out_valid=0, in_ready=0.
- Storage contents are not reset.
- After resetn deasserts, in_ready goes to 1 on the first rising clk edge.
- Storage is a circular buffer. wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally (DEPTH is a power of two).
- push = in_valid && in_ready. On push, mem[wr_ptr] <= in_data and wr_ptr increments.
- pop = out_valid && out_ready. On pop, rd_ptr increments.
- next_count = count + push - pop. count is registered.
- in_ready <= (next_count != DEPTH).
- out_valid <= (next_count != 0).
- out_data = mem[rd_ptr]. This read mux is driven only by registers.
- Latency: a beat accepted at edge N is presented with out_valid=1 after edge N, one cycle later.
- Throughput: one beat per cycle with out_ready held at 1, for any DEPTH >= 2.
- Full (count==DEPTH): in_ready=0, so in_valid is ignored. A pop in that cycle raises in_ready after the edge; the blocked beat is accepted no earlier than the next cycle.
- Empty (count==0): out_valid=0. out_ready is don't-care and no pop occurs.
- Push and pop in the same cycle: count is unchanged and both pointers advance. This is legal at every occupancy 1..DEPTH-1.
- Stall: while out_valid && !out_ready, out_data and out_valid are held stable.
- Upstream must hold in_data stable while in_valid && !in_ready; the block does not check this.
- Ordering: strict FIFO. No beat is dropped or duplicated.
- count never exceeds DEPTH and never underflows. The bench asserts both invariants.

Optional Feature:
- Macro: SKID_FIFO_FALLTHROUGH_EN.
- Defined: while count==0, out_valid = in_valid and out_data = in_data combinationally.
- Defined, empty, in_valid && out_ready: the beat bypasses storage. No push, no pop; count stays 0 and the pointers stay put.
- Defined, empty, in_valid && !out_ready: the beat is pushed as normal.
- Defined, count!=0: behaviour is identical to the undefined build.
- Defined: empty-path latency is 0 cycles, at the cost of an in_valid->out_valid combinational path.
- Undefined: all outputs are registered and latency is 1 cycle in every case.

Test Plan:
- Reset: hold resetn=0 for 3 cycles -> in_ready=0, out_valid=0, count=0. Release resetn -> in_ready=1 after the first edge.
- Streaming, DEPTH=4: out_ready=1, in_valid=1, data 0x01..0x10 over 16 cycles -> out sees 0x01..0x10 in order, one per cycle, starting one cycle after the first accept; count <= 1 throughout.
- Fill: out_ready=0, push 0xA0..0xA3 -> count=4 and in_ready=0 after the 4th accept. 0xA4 is offered and held, not accepted. out_data=0xA0 stays stable.
- Full plus simultaneous drain: from the fill state, out_ready=1 for one cycle with in_valid=1 (0xA4) -> 0xA0 pops and 0xA4 is not pushed that cycle. Next cycle in_ready=1 and 0xA4 is accepted; count returns to 4.
- Mid-operation reset: count=3, drop resetn between clock edges -> out_valid=0, in_ready=0, count=0 immediately. After release, the first beat out is the first beat pushed after reset.
- Fallthrough (macro defined): empty, in_valid=1, out_ready=1, data 0x55 -> out_valid=1 and out_data=0x55 in the same cycle, count stays 0. With the macro undefined, the same stimulus gives 0x55 one cycle later.

Source files
------------

// File: rtl/skid_fifo.sv
// skid_fifo: DEPTH-entry elastic buffer between two valid/ready interfaces.
//   in_ready and out_valid are taken straight from flops, so no combinational
//   path links the upstream and downstream handshakes. One beat per cycle.
//
// Optional feature: define SKID_FIFO_FALLTHROUGH_EN to let a beat bypass
//   storage while the buffer is empty (zero-latency empty path, at the cost of
//   an in_valid->out_valid combinational path). Undefined: fully registered.
//
// Ports:
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   in_data    upstream payload          in_valid  upstream valid
//   in_ready   registered ready upstream
//   out_data   payload from storage      out_valid registered valid downstream
//   out_ready  downstream ready
//   count      occupancy, 0..DEPTH
module skid_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("skid_fifo: DEPTH must be a power of two and >= 2");
  end

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          in_ready_q, out_valid_q;
  logic          push, pop;

  // pop only ever happens on a registered valid, i.e. when storage holds data
  assign pop = out_valid_q && out_ready;

`ifdef SKID_FIFO_FALLTHROUGH_EN
  logic empty, bypass;
  assign empty  = (count_q == '0);
  // in_ready_q gates the bypass so nothing leaks out while in reset
  assign bypass = empty && in_valid && in_ready_q && out_ready;
  assign push   = in_valid && in_ready_q && !bypass;
  always_comb begin
    out_valid = out_valid_q;
    out_data  = mem_q[rd_ptr_q];
    if (empty) begin
      out_valid = in_valid && in_ready_q;
      out_data  = in_data;
    end
  end
`else
  assign push      = in_valid && in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = mem_q[rd_ptr_q];
`endif

  assign count_d  = count_q + CW'(push) - CW'(pop);
  assign in_ready = in_ready_q;
  assign count    = count_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_d;
      in_ready_q  <= (count_d != CW'(DEPTH));
      out_valid_q <= (count_d != '0);
    end
  end

  // storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_skid_fifo.sv
module tb_skid_fifo;

`ifdef SKID_FIFO_FALLTHROUGH_EN
  localparam bit FT = 1'b1;
`else
  localparam bit FT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  count;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  skid_fifo #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .resetn(resetn),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count)
  );

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_od;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic iv, logic [31:0] d, logic ordy,
                              logic e_ir, logic e_ov, logic [31:0] e_od,
                              logic [2:0] e_cnt);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s[%0d] got=0x%0h expected=0x%0h", nm, idx, act, exp);
    end
  endtask

  // Drive one vector mid-cycle and compare the outputs the DUT shows before
  // the next rising edge consumes those inputs.
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    in_valid  = v.iv;
    in_data   = v.d;
    out_ready = v.ordy;
    #1;
    chk("in_ready", idx, 32'(in_ready), 32'(v.e_ir));
    chk("out_valid", idx, 32'(out_valid), 32'(v.e_ov));
    chk("count", idx, 32'(count), 32'(v.e_cnt));
    if (v.e_ov) chk("out_data", idx, out_data, v.e_od);
  endtask

  // occupancy invariant, checked every cycle out of reset
  always @(negedge clk) begin
    if (resetn) begin
      compared++;
      if (count > 3'd4) begin
        mismatched++;
        $display("FAIL count_bound got=%0d expected<=4", count);
      end
    end
  end

  initial begin
    // ---- reset held for 3 cycles ----
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", 0, 32'(in_ready), 32'd0);
    chk("rst_out_valid", 0, 32'(out_valid), 32'd0);
    chk("rst_count", 0, 32'(count), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("rel_in_ready_pre", 0, 32'(in_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("rel_in_ready_post", 0, 32'(in_ready), 32'd1);

    // ---- streaming 0x01..0x10, out_ready=1 ----
    for (int i = 0; i < 16; i++) begin
      if (FT) tbl.push_back(mk(1'b1, 32'(i + 1), 1'b1, 1'b1, 1'b1, 32'(i + 1), 3'd0));
      else    tbl.push_back(mk(1'b1, 32'(i + 1), 1'b1, 1'b1, i >= 1, 32'(i), (i >= 1) ? 3'd1 : 3'd0));
    end
    tbl.push_back(mk(1'b0, '0, 1'b1, 1'b1, !FT, 32'h10, FT ? 3'd0 : 3'd1));
    tbl.push_back(mk(1'b0, '0, 1'b1, 1'b1, 1'b0, '0, 3'd0));

    // ---- fill with out_ready=0 ----
    tbl.push_back(mk(1'b1, 32'hA0, 1'b0, 1'b1, FT, 32'hA0, 3'd0));
    tbl.push_back(mk(1'b1, 32'hA1, 1'b0, 1'b1, 1'b1, 32'hA0, 3'd1));
    tbl.push_back(mk(1'b1, 32'hA2, 1'b0, 1'b1, 1'b1, 32'hA0, 3'd2));
    tbl.push_back(mk(1'b1, 32'hA3, 1'b0, 1'b1, 1'b1, 32'hA0, 3'd3));
    tbl.push_back(mk(1'b1, 32'hA4, 1'b0, 1'b0, 1'b1, 32'hA0, 3'd4));
    tbl.push_back(mk(1'b1, 32'hA4, 1'b0, 1'b0, 1'b1, 32'hA0, 3'd4));
    // ---- full plus drain: A0 pops, A4 blocked this cycle ----
    tbl.push_back(mk(1'b1, 32'hA4, 1'b1, 1'b0, 1'b1, 32'hA0, 3'd4));
    tbl.push_back(mk(1'b1, 32'hA4, 1'b0, 1'b1, 1'b1, 32'hA1, 3'd3));
    tbl.push_back(mk(1'b0, '0, 1'b0, 1'b0, 1'b1, 32'hA1, 3'd4));
    // ---- drain with a simultaneous push/pop at occupancy 3 ----
    tbl.push_back(mk(1'b0, '0, 1'b1, 1'b0, 1'b1, 32'hA1, 3'd4));
    tbl.push_back(mk(1'b1, 32'hD0, 1'b1, 1'b1, 1'b1, 32'hA2, 3'd3));
    tbl.push_back(mk(1'b0, '0, 1'b1, 1'b1, 1'b1, 32'hA3, 3'd3));
    tbl.push_back(mk(1'b0, '0, 1'b1, 1'b1, 1'b1, 32'hA4, 3'd2));
    tbl.push_back(mk(1'b0, '0, 1'b1, 1'b1, 1'b1, 32'hD0, 3'd1));
    tbl.push_back(mk(1'b0, '0, 1'b1, 1'b1, 1'b0, '0, 3'd0));
    // ---- empty-path latency with 0x55 ----
    tbl.push_back(mk(1'b1, 32'h55, 1'b1, 1'b1, FT, 32'h55, 3'd0));
    tbl.push_back(mk(1'b0, '0, 1'b1, 1'b1, !FT, 32'h55, FT ? 3'd0 : 3'd1));
    tbl.push_back(mk(1'b0, '0, 1'b1, 1'b1, 1'b0, '0, 3'd0));
    // ---- stall stability: hold one beat with out_ready=0 ----
    tbl.push_back(mk(1'b1, 32'h77, 1'b0, 1'b1, FT, 32'h77, 3'd0));
    tbl.push_back(mk(1'b0, 32'hFF, 1'b0, 1'b1, 1'b1, 32'h77, 3'd1));
    tbl.push_back(mk(1'b0, 32'hFF, 1'b0, 1'b1, 1'b1, 32'h77, 3'd1));
    tbl.push_back(mk(1'b0, '0, 1'b1, 1'b1, 1'b1, 32'h77, 3'd1));
    tbl.push_back(mk(1'b0, '0, 1'b1, 1'b1, 1'b0, '0, 3'd0));

    foreach (tbl[i]) apply(tbl[i], i);

    // ---- mid-operation reset at count=3 ----
    apply(mk(1'b1, 32'hB0, 1'b0, 1'b1, FT, 32'hB0, 3'd0), 100);
    apply(mk(1'b1, 32'hB1, 1'b0, 1'b1, 1'b1, 32'hB0, 3'd1), 101);
    apply(mk(1'b1, 32'hB2, 1'b0, 1'b1, 1'b1, 32'hB0, 3'd2), 102);
    apply(mk(1'b0, '0, 1'b0, 1'b1, 1'b1, 32'hB0, 3'd3), 103);
    #2;
    resetn = 1'b0;
    #1;
    chk("mrst_out_valid", 104, 32'(out_valid), 32'd0);
    chk("mrst_in_ready", 104, 32'(in_ready), 32'd0);
    chk("mrst_count", 104, 32'(count), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    apply(mk(1'b1, 32'hC0, 1'b1, 1'b1, FT, 32'hC0, 3'd0), 105);
    apply(mk(1'b1, 32'hC1, 1'b1, 1'b1, 1'b1, FT ? 32'hC1 : 32'hC0, FT ? 3'd0 : 3'd1), 106);
    apply(mk(1'b0, '0, 1'b1, 1'b1, !FT, 32'hC1, FT ? 3'd0 : 3'd1), 107);
    apply(mk(1'b0, '0, 1'b1, 1'b1, 1'b0, '0, 3'd0), 108);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
